// File: rtl/switch_debounce_events_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_events_if
// Description : Bundle of the conditioned switch outputs and the sticky
//               press-event handshake between the switch block and the CPU.
//   o_Sw_Level   : debounced stable level per switch
//   o_Sw_Press   : one-cycle pulse on debounced 0->1
//   o_Sw_Release : one-cycle pulse on debounced 1->0
//   o_Evt_Mask   : sticky press flags
//   o_Evt_Valid  : any flag set
//   i_Evt_Ack    : CPU acknowledge, clears the flags
//   slave  modport : switch block side (drives the o_* signals)
//   master modport : CPU side (drives i_Evt_Ack)
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_debounce_events_if #(
  parameter int NUM_SW = 4
);
  logic [NUM_SW-1:0] o_Sw_Level;
  logic [NUM_SW-1:0] o_Sw_Press;
  logic [NUM_SW-1:0] o_Sw_Release;
  logic [NUM_SW-1:0] o_Evt_Mask;
  logic              o_Evt_Valid;
  logic              i_Evt_Ack;

  modport slave (
    output o_Sw_Level,
    output o_Sw_Press,
    output o_Sw_Release,
    output o_Evt_Mask,
    output o_Evt_Valid,
    input  i_Evt_Ack
  );

  modport master (
    input  o_Sw_Level,
    input  o_Sw_Press,
    input  o_Sw_Release,
    input  o_Evt_Mask,
    input  o_Evt_Valid,
    output i_Evt_Ack
  );
endinterface
`default_nettype wire

// File: rtl/switch_debounce_events.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_events
// Description : Conditions raw board switches into clean CPU-facing signals.
//               Per switch: 2-flop synchronizer, counter debouncer and
//               registered press/release pulses. Presses also set a sticky
//               flag that the CPU polls and clears with a valid/ack handshake.
// Ports       :
//   i_Clk    : system clock, rising edge
//   i_Rst_n  : asynchronous active-low reset
//   i_Switch : raw switch levels, active-high, asynchronous to i_Clk
//   evt      : switch_debounce_events_if.slave (levels, pulses, event mask,
//              valid, ack)
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce_events #(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic [NUM_SW-1:0]      i_Switch,
  switch_debounce_events_if.slave evt
);

  // Terminal count: the new level is accepted on the edge the counter
  // would otherwise step past this value.
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] w_level;
  logic [NUM_SW-1:0] w_press;
  logic [NUM_SW-1:0] w_release;
  logic [NUM_SW-1:0] w_mask;

  generate
    for (genvar n = 0; n < NUM_SW; n++) begin : g_sw
      logic             r_meta;
      logic             r_sync;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             r_mask;
      logic [CNT_W-1:0] r_cnt;
      logic             w_accept;
      logic             w_press_next;

      // Synchronized input has differed from the stable level for
      // DEBOUNCE_CYCLES consecutive cycles.
      assign w_accept     = (r_sync != r_level) && (r_cnt == c_CNT_MAX);
      assign w_press_next = w_accept && r_sync;

      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          r_meta    <= 1'b0;
          r_sync    <= 1'b0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          r_mask    <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_meta    <= i_Switch[n];
          r_sync    <= r_meta;
          r_press   <= w_press_next;
          r_release <= w_accept && !r_sync;
          // Set wins over a coincident acknowledge so no press is lost.
          r_mask    <= (r_mask & ~evt.i_Evt_Ack) | w_press_next;

          if (r_sync == r_level) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            r_level <= r_sync;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_level[n]   = r_level;
      assign w_press[n]   = r_press;
      assign w_release[n] = r_release;
      assign w_mask[n]    = r_mask;
    end
  endgenerate

  assign evt.o_Sw_Level   = w_level;
  assign evt.o_Sw_Press   = w_press;
  assign evt.o_Sw_Release = w_release;
  assign evt.o_Evt_Mask   = w_mask;
  assign evt.o_Evt_Valid  = |w_mask;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_events.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debounce_events
// Description : Directed self-checking bench for switch_debounce_events with
//               DEBOUNCE_CYCLES = 4 (6-edge press/release latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce_events;

  logic       i_Clk;
  logic       i_Rst_n;
  logic [3:0] i_Switch;
  int         n_checks;
  int         n_fail;

  switch_debounce_events_if #(.NUM_SW(4)) evt_if ();

  switch_debounce_events #(
    .NUM_SW          (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_Switch (i_Switch),
    .evt      (evt_if.slave)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic test_reset;
    i_Rst_n = 1'b0;
    step(3);
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0000) begin n_fail++; $display("FAIL reset_level: got %b expected %b", evt_if.o_Sw_Level, 4'b0000); end
    n_checks++; if (evt_if.o_Sw_Press !== 4'b0000) begin n_fail++; $display("FAIL reset_press: got %b expected %b", evt_if.o_Sw_Press, 4'b0000); end
    n_checks++; if (evt_if.o_Sw_Release !== 4'b0000) begin n_fail++; $display("FAIL reset_release: got %b expected %b", evt_if.o_Sw_Release, 4'b0000); end
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b0000) begin n_fail++; $display("FAIL reset_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b0000); end
    n_checks++; if (evt_if.o_Evt_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected %b", evt_if.o_Evt_Valid, 1'b0); end
    i_Rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_clean_press;
    i_Switch = 4'b0001;
    step(5);
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0000) begin n_fail++; $display("FAIL press_early_level: got %b expected %b", evt_if.o_Sw_Level, 4'b0000); end
    n_checks++; if (evt_if.o_Sw_Press !== 4'b0000) begin n_fail++; $display("FAIL press_early_pulse: got %b expected %b", evt_if.o_Sw_Press, 4'b0000); end
    step(1);
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0001) begin n_fail++; $display("FAIL press_level: got %b expected %b", evt_if.o_Sw_Level, 4'b0001); end
    n_checks++; if (evt_if.o_Sw_Press !== 4'b0001) begin n_fail++; $display("FAIL press_pulse: got %b expected %b", evt_if.o_Sw_Press, 4'b0001); end
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b0001) begin n_fail++; $display("FAIL press_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b0001); end
    n_checks++; if (evt_if.o_Evt_Valid !== 1'b1) begin n_fail++; $display("FAIL press_valid: got %b expected %b", evt_if.o_Evt_Valid, 1'b1); end
    step(1);
    n_checks++; if (evt_if.o_Sw_Press !== 4'b0000) begin n_fail++; $display("FAIL press_one_cycle: got %b expected %b", evt_if.o_Sw_Press, 4'b0000); end
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0001) begin n_fail++; $display("FAIL press_level_hold: got %b expected %b", evt_if.o_Sw_Level, 4'b0001); end
  endtask

  task automatic test_release;
    i_Switch = 4'b0000;
    step(5);
    n_checks++; if (evt_if.o_Sw_Release !== 4'b0000) begin n_fail++; $display("FAIL release_early: got %b expected %b", evt_if.o_Sw_Release, 4'b0000); end
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0001) begin n_fail++; $display("FAIL release_early_level: got %b expected %b", evt_if.o_Sw_Level, 4'b0001); end
    step(1);
    n_checks++; if (evt_if.o_Sw_Release !== 4'b0001) begin n_fail++; $display("FAIL release_pulse: got %b expected %b", evt_if.o_Sw_Release, 4'b0001); end
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0000) begin n_fail++; $display("FAIL release_level: got %b expected %b", evt_if.o_Sw_Level, 4'b0000); end
    n_checks++; if (evt_if.o_Sw_Press !== 4'b0000) begin n_fail++; $display("FAIL release_no_press: got %b expected %b", evt_if.o_Sw_Press, 4'b0000); end
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b0001) begin n_fail++; $display("FAIL release_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b0001); end
    step(1);
    n_checks++; if (evt_if.o_Sw_Release !== 4'b0000) begin n_fail++; $display("FAIL release_one_cycle: got %b expected %b", evt_if.o_Sw_Release, 4'b0000); end
  endtask

  task automatic test_ack_vs_press;
    i_Switch = 4'b1000;
    step(5);
    evt_if.i_Evt_Ack = 1'b1;
    step(1);
    evt_if.i_Evt_Ack = 1'b0;
    n_checks++; if (evt_if.o_Sw_Press !== 4'b1000) begin n_fail++; $display("FAIL ackpress_pulse: got %b expected %b", evt_if.o_Sw_Press, 4'b1000); end
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b1000) begin n_fail++; $display("FAIL ackpress_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b1000); end
    n_checks++; if (evt_if.o_Evt_Valid !== 1'b1) begin n_fail++; $display("FAIL ackpress_valid: got %b expected %b", evt_if.o_Evt_Valid, 1'b1); end
    step(1);
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b1000) begin n_fail++; $display("FAIL ackpress_mask_hold: got %b expected %b", evt_if.o_Evt_Mask, 4'b1000); end
    evt_if.i_Evt_Ack = 1'b1;
    step(1);
    evt_if.i_Evt_Ack = 1'b0;
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b0000) begin n_fail++; $display("FAIL ack_clear_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b0000); end
    n_checks++; if (evt_if.o_Evt_Valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear_valid: got %b expected %b", evt_if.o_Evt_Valid, 1'b0); end
  endtask

  task automatic test_bounce;
    logic [3:0] pattern [4];
    pattern[0] = 4'b1010;
    pattern[1] = 4'b1000;
    pattern[2] = 4'b1010;
    pattern[3] = 4'b1000;
    for (int p = 0; p < 4; p++) begin
      i_Switch = pattern[p];
      for (int c = 0; c < 2; c++) begin
        step(1);
        n_checks++; if (evt_if.o_Sw_Press !== 4'b0000) begin n_fail++; $display("FAIL bounce_press p%0d c%0d: got %b expected %b", p, c, evt_if.o_Sw_Press, 4'b0000); end
        n_checks++; if (evt_if.o_Sw_Level !== 4'b1000) begin n_fail++; $display("FAIL bounce_level p%0d c%0d: got %b expected %b", p, c, evt_if.o_Sw_Level, 4'b1000); end
      end
    end
    i_Switch = 4'b1010;
    step(5);
    n_checks++; if (evt_if.o_Sw_Level !== 4'b1000) begin n_fail++; $display("FAIL bounce_settle_early: got %b expected %b", evt_if.o_Sw_Level, 4'b1000); end
    step(1);
    n_checks++; if (evt_if.o_Sw_Level !== 4'b1010) begin n_fail++; $display("FAIL bounce_settle_level: got %b expected %b", evt_if.o_Sw_Level, 4'b1010); end
    n_checks++; if (evt_if.o_Sw_Press !== 4'b0010) begin n_fail++; $display("FAIL bounce_settle_press: got %b expected %b", evt_if.o_Sw_Press, 4'b0010); end
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b0010) begin n_fail++; $display("FAIL bounce_settle_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b0010); end
    step(1);
    n_checks++; if (evt_if.o_Sw_Press !== 4'b0000) begin n_fail++; $display("FAIL bounce_single_pulse: got %b expected %b", evt_if.o_Sw_Press, 4'b0000); end
  endtask

  task automatic test_reset_mid;
    i_Switch = 4'b1110;
    step(4);
    #2;
    i_Rst_n = 1'b0;
    #1;
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0000) begin n_fail++; $display("FAIL midrst_level: got %b expected %b", evt_if.o_Sw_Level, 4'b0000); end
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b0000) begin n_fail++; $display("FAIL midrst_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b0000); end
    n_checks++; if (evt_if.o_Evt_Valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected %b", evt_if.o_Evt_Valid, 1'b0); end
    i_Switch = 4'b0100;
    step(2);
    i_Rst_n = 1'b1;
    step(5);
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0000) begin n_fail++; $display("FAIL postrst_early_level: got %b expected %b", evt_if.o_Sw_Level, 4'b0000); end
    step(1);
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0100) begin n_fail++; $display("FAIL postrst_level: got %b expected %b", evt_if.o_Sw_Level, 4'b0100); end
    n_checks++; if (evt_if.o_Sw_Press !== 4'b0100) begin n_fail++; $display("FAIL postrst_press: got %b expected %b", evt_if.o_Sw_Press, 4'b0100); end
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b0100) begin n_fail++; $display("FAIL postrst_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b0100); end
  endtask

  task automatic test_simultaneous;
    i_Switch = 4'b0000;
    step(8);
    evt_if.i_Evt_Ack = 1'b1;
    step(1);
    evt_if.i_Evt_Ack = 1'b0;
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b0000) begin n_fail++; $display("FAIL simul_pre_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b0000); end
    i_Switch = 4'b1111;
    evt_if.i_Evt_Ack = 1'b1;
    step(5);
    n_checks++; if (evt_if.o_Sw_Level !== 4'b0000) begin n_fail++; $display("FAIL simul_early_level: got %b expected %b", evt_if.o_Sw_Level, 4'b0000); end
    step(1);
    n_checks++; if (evt_if.o_Sw_Press !== 4'b1111) begin n_fail++; $display("FAIL simul_press: got %b expected %b", evt_if.o_Sw_Press, 4'b1111); end
    n_checks++; if (evt_if.o_Sw_Level !== 4'b1111) begin n_fail++; $display("FAIL simul_level: got %b expected %b", evt_if.o_Sw_Level, 4'b1111); end
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b1111) begin n_fail++; $display("FAIL simul_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b1111); end
    n_checks++; if (evt_if.o_Evt_Valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid: got %b expected %b", evt_if.o_Evt_Valid, 1'b1); end
    step(1);
    n_checks++; if (evt_if.o_Evt_Mask !== 4'b0000) begin n_fail++; $display("FAIL held_ack_mask: got %b expected %b", evt_if.o_Evt_Mask, 4'b0000); end
    n_checks++; if (evt_if.o_Evt_Valid !== 1'b0) begin n_fail++; $display("FAIL held_ack_valid: got %b expected %b", evt_if.o_Evt_Valid, 1'b0); end
    n_checks++; if (evt_if.o_Sw_Press !== 4'b0000) begin n_fail++; $display("FAIL simul_one_cycle: got %b expected %b", evt_if.o_Sw_Press, 4'b0000); end
    evt_if.i_Evt_Ack = 1'b0;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    i_Rst_n          = 1'b0;
    i_Switch         = 4'b0000;
    evt_if.i_Evt_Ack = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_ack_vs_press();
    test_bounce();
    test_reset_mid();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_debounce_events.md
Name: switch_debounce_events

Overview:
- Input-side counterpart to the board LED drivers: conditions the four raw board switches (i_Switch_1..4) into clean, CPU-consumable signals.
- Per switch: 2-flop synchronizer, counter-based debouncer, registered press/release pulses.
- A sticky press-event register with a valid/ack handshake lets the CPU poll switch presses without missing short events.

Parameters:
- NUM_SW, 4, number of switch channels.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronized cycles required to accept a new level (10 ms at 25 MHz); legal range 2..2^CNT_W.
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- i_Clk  input  1  system clock, all logic on rising edge.
- i_Rst_n  input  1  reset, asynchronous assert, active-low.
- i_Switch  input  NUM_SW  raw switch levels, active-high (pressed = 1), asynchronous to i_Clk; bit n = board switch n+1.
- o_Sw_Level  output  NUM_SW  debounced stable level per switch.
- o_Sw_Press  output  NUM_SW  one-cycle pulse on debounced 0->1.
- o_Sw_Release  output  NUM_SW  one-cycle pulse on debounced 1->0.
- o_Evt_Mask  output  NUM_SW  sticky press flags, one per switch.
- o_Evt_Valid  output  1  OR-reduction of o_Evt_Mask (combinational from registered mask).
- i_Evt_Ack  input  1  CPU acknowledge; clears o_Evt_Mask.

Behaviour:
- Reset (i_Rst_n = 0, asynchronous): sync flops, debounced levels, counters, pulse outputs and event mask all go to 0. So o_Sw_Level = 0, o_Sw_Press = 0, o_Sw_Release = 0, o_Evt_Mask = 0, o_Evt_Valid = 0.
- Reset mid-debounce discards the partial count.
- Synchronizer: two flops per bit, reset to 0. Sync output s[n] is the only input the debouncer sees.
- Debouncer (per bit, independent). State: stable level L[n] and counter c[n].
  - s == L: c <= 0.
  - s != L and c < DEBOUNCE_CYCLES-1: c <= c+1.
  - s != L and c == DEBOUNCE_CYCLES-1: L <= s, c <= 0.
  - Any return of s to L before acceptance restarts the count from 0. Bounces shorter than DEBOUNCE_CYCLES are filtered.
- Latency: a clean input change first sampled at rising edge k appears on o_Sw_Level after edge k+DEBOUNCE_CYCLES+1.
  - That is, DEBOUNCE_CYCLES+2 edges counting edge k.
  - Releases use the same latency.
- Pulses: registered. o_Sw_Press[n] / o_Sw_Release[n] are high for exactly the one cycle in which o_Sw_Level[n] has just changed (same edge as the L update). They are never both high for the same bit.
- Event mask, next state per bit: mask[n] <= (mask[n] & ~i_Evt_Ack) | press_next[n].
  - A press arriving on the same edge as an ack is retained (set wins).
  - Releases never touch the mask.
  - Repeated presses while the flag is already set do not count; the flag stays 1.
- Handshake: the CPU reads o_Evt_Mask while o_Evt_Valid = 1, then pulses i_Evt_Ack for one cycle.
  - Ack with an empty mask is a no-op.
  - Ack held high continuously clears each flag one cycle after it sets. The flag is still visible for one cycle.
- Switch held high through reset: after deassertion it produces a normal press (level, pulse, flag) at the standard latency.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

Test Plan (bench uses DEBOUNCE_CYCLES = 4, CNT_W = 3):
- Clean press: i_Switch = 4'b0001 from edge k -> o_Sw_Level[0] = 1 after edge k+5; o_Sw_Press = 4'b0001 for exactly that cycle; o_Evt_Mask = 4'b0001; o_Evt_Valid = 1; other bits stay 0.
- Bounce rejection: i_Switch[1] toggles 1,0,1,0 with 2-cycle high/low widths, then holds 1 -> no pulses during toggling; o_Sw_Level[1] rises exactly 6 edges after the final sampled 0->1; single o_Sw_Press pulse.
- Release: after the first scenario, drop i_Switch[0] -> o_Sw_Release[0] one-cycle pulse at the same latency; o_Evt_Mask unchanged (4'b0001).
- Ack vs new press on the same edge: mask = 4'b0001; switch 3 press pulse coincides with the i_Evt_Ack edge -> o_Evt_Mask = 4'b1000 afterwards; o_Evt_Valid stays 1. A next ack -> mask = 0, o_Evt_Valid = 0.
- Simultaneous channels: i_Switch = 4'b1111 at the same edge -> o_Sw_Press = 4'b1111 in one cycle; o_Evt_Mask = 4'b1111.
- Reset mid-operation: assert i_Rst_n = 0 asynchronously (between edges) with count at 2 and mask = 4'b0010 -> all outputs 0 immediately. After deassertion with i_Switch[2] held 1 -> press on bit 2 at the full 6-edge latency.
